fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Controller that sequences the instruction fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and issues requests to instruction memory under a req/ready handshake; memory may take several cycles.
- Writes the IF/ID pipeline register, honours hazard-unit stalls through a one-entry holding buffer, and applies branch/jump redirects with IF/ID flush.
- Sits between the hazard/branch logic in ID and instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- ADDR_W, 32, PC/address width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit: ID not accepting; IF/ID must hold.
- BranchTaken  in  1  one-cycle pulse from ID: taken branch.
- BranchTarget  in  ADDR_W  branch destination.
- Jump  in  1  one-cycle pulse from ID: jump.
- JumpTarget  in  ADDR_W  jump destination.
- ImemReq  out  1  instruction memory request.
- ImemAddr  out  ADDR_W  fetch address; stable while ImemReq=1 and ImemReady=0.
- ImemReady  in  1  memory response valid this cycle (only meaningful while ImemReq=1).
- ImemData  in  32  instruction word, valid with ImemReady.
- IfIdValid  out  1  IF/ID holds a live instruction.
- IfIdInstr  out  32  IF/ID instruction.
- IfIdPC4  out  ADDR_W  IF/ID PC+4.
- Flush  out  1  registered one-cycle pulse the cycle after a redirect is accepted.

Behaviour:
- Reset (async, Reset=0) values:
  - PC=RESET_PC, state IDLE, buffer empty.
  - ImemReq=0, ImemAddr=RESET_PC.
  - IfIdValid=0, IfIdInstr=0, IfIdPC4=0, Flush=0.
  - Any response in flight at reset is ignored.
- IDLE: one cycle after Reset release -> REQ. No request issued in IDLE.
- REQ (ImemReq=1, ImemAddr=PC):
  - ImemReady=0, Stall=0: IfIdValid<=0 (bubble).
  - ImemReady=0, Stall=1: IF/ID holds.
  - ImemReady=1, Stall=0: IfIdInstr<=ImemData, IfIdPC4<=PC+4, IfIdValid<=1, PC<=PC+4; stay REQ. Back-to-back fetch allowed, one instruction per cycle with a zero-wait memory.
  - ImemReady=1, Stall=1: word and PC+4 go to the holding buffer, PC<=PC+4, -> HOLD. IF/ID unchanged.
- HOLD (ImemReq=0):
  - IF/ID holds while Stall=1.
  - First cycle with Stall=0: buffer -> IF/ID, IfIdValid<=1, buffer emptied, -> REQ.
- Redirect:
  - Accepted in any state when BranchTaken|Jump=1. BranchTaken has priority over Jump when both are asserted.
  - Redirect overrides Stall.
  - Target low 2 bits are forced to 00.
  - Next cycle: PC=target, IfIdValid=0, buffer emptied, Flush=1 (exactly one cycle).
- Redirect versus an outstanding request:
  - Outstanding request (REQ, ImemReady=0): the request is not aborted. -> DRAIN, where ImemReq/ImemAddr are held until ImemReady, the data is discarded, then -> REQ at target.
  - Redirect coinciding with ImemReady: data discarded, -> REQ at target next cycle.
  - Redirect in IDLE or HOLD: -> REQ at target.
  - A further redirect during DRAIN replaces the pending target; Flush pulses again.
- Arithmetic: PC+4 is computed modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0, with no error flag.
- ImemAddr always equals PC except in DRAIN, where it holds the old address.

Decomposition:
- Shared package mips_fetch_pkg: state encoding (IDLE, REQ, HOLD, DRAIN), default RESET_PC, PC increment constant 4, NOP word 32'h0000_0000.
- One sub-module, fetch_hold_buffer: a one-entry register for {instr, pc4} with load/clear/valid. The sequencer FSM and PC live in fetch_sequencer.

Test Plan:
1. Reset then zero-wait memory (ImemReady=1 always, data=addr+1):
   - ImemAddr steps 0,4,8,...
   - IfIdInstr 1,5,9 on consecutive cycles; IfIdPC4 4,8,12; IfIdValid=1 continuously from cycle 3 after reset release.
2. Memory with 2 wait cycles per access:
   - ImemAddr held stable across the wait cycles.
   - IfIdValid pattern 0,0,1 repeating; PC advances only on ImemReady.
3. Stall=1 for 3 cycles while the word at 0x8 returns:
   - IF/ID holds the 0x4 instruction; ImemReq=0 during HOLD.
   - On Stall release, IfIdInstr = word@0x8 and IfIdPC4=0xC; fetch resumes at 0xC.
4. BranchTaken=1, BranchTarget=0x103 while a fetch at 0x10 is outstanding:
   - DRAIN holds ImemAddr=0x10 until ready; that data is discarded.
   - Flush=1 for one cycle; next ImemAddr=0x100; IfIdValid=0 until the 0x100 word arrives.
5. BranchTaken and Jump asserted together (targets 0x200 / 0x300) with Stall=1:
   - Fetch goes to 0x200.
   - Buffer cleared, Flush pulse, stall ignored for the redirect.
6. Reset asserted mid-DRAIN, and separately PC=0xFFFF_FFFC:
   - Reset: all outputs return to reset values asynchronously; the first request after release is at RESET_PC.
   - Wrap: the next ImemAddr is 0x0 and IfIdPC4=0x0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch sequencer.
package mips_fetch_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register for a fetched {instr, pc4} pair that arrived while
// ID was stalled. Clear wins over load.
module fetch_hold_buffer
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc4_in,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    // Next-entry selection: clear empties, load captures a new pair
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc4_d   = pc4_in;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, talks to instruction memory,
// loads IF/ID, parks a word in the hold buffer on stalls and applies redirects.
//
// Memory handshake: ImemReq/ImemAddr act as the request "valid"; once raised,
// ImemAddr stays stable until the cycle ImemReady=1, which both completes the
// transfer and qualifies ImemData. ImemReady is ignored whenever ImemReq=0.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemReady,
    input  logic [31:0]       ImemData,
    output logic              IfIdValid,
    output logic [31:0]       IfIdInstr,
    output logic [ADDR_W-1:0] IfIdPC4,
    output logic              Flush,
    output logic [1:0]        dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic              flush_q, flush_d;

    logic              buf_load, buf_clear, buf_valid;
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc4;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_sel, redirect_target, pc_plus4;

    assign redirect        = BranchTaken | Jump;
    assign redirect_sel    = BranchTaken ? BranchTarget : JumpTarget;
    assign redirect_target = redirect_sel & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign pc_plus4        = pc_q + ADDR_W'(PC_INCR);

    fetch_hold_buffer #(.ADDR_W(ADDR_W)) u_hold (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (ImemData),
        .pc4_in   (pc_plus4),
        .valid    (buf_valid),
        .instr    (buf_instr),
        .pc4      (buf_pc4)
    );

    // Next-state, PC and IF/ID update; a redirect overrides everything else
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        flush_d      = 1'b0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        if (redirect) begin
            pc_d         = redirect_target;
            ifid_valid_d = 1'b0;
            buf_clear    = 1'b1;
            flush_d      = 1'b1;
            state_d      = ST_REQ;
            if (state_q == ST_REQ && !ImemReady) begin
                // Memory still owes us a word: let it land, then discard it
                state_d      = ST_DRAIN;
                drain_addr_d = pc_q;
            end else if (state_q == ST_DRAIN && !ImemReady) begin
                state_d = ST_DRAIN;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (ImemReady) begin
                        pc_d = pc_plus4;
                        if (Stall) begin
                            buf_load = 1'b1;
                            state_d  = ST_HOLD;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = ImemData;
                            ifid_pc4_d   = pc_plus4;
                        end
                    end else if (!Stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        ifid_valid_d = buf_valid;
                        ifid_instr_d = buf_instr;
                        ifid_pc4_d   = buf_pc4;
                        buf_clear    = 1'b1;
                        state_d      = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (ImemReady) state_d = ST_REQ;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, PC and IF/ID registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= '0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            flush_q      <= flush_d;
        end
    end

    assign ImemReq   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign ImemAddr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign IfIdValid = ifid_valid_q;
    assign IfIdInstr = ifid_instr_q;
    assign IfIdPC4   = ifid_pc4_q;
    assign Flush     = flush_q;
    assign dbg_state = state_q;

endmodule
